// File: rtl/ram_dump_sequencer.sv
// Hands the data-RAM port to a dump engine once the CPU ends execution and streams every
// word MSB-first to the UART. Optional trailing XOR checksum byte: define DUMP_CHECKSUM_EN.
module ram_dump_sequencer #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 16,
    parameter int WORD_COUNT = 64,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              eoe,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_HI   = 3'd3,
        ST_LO   = 3'd4,
`ifdef DUMP_CHECKSUM_EN
        ST_CSUM = 3'd5,
`endif
        ST_DONE = 3'd6
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W + 1)'(WORD_COUNT - 1);
    localparam logic [1:0]      WAIT_LAST = 2'(RD_LAT - 1);

    state_t            state_r;
    logic [ADDR_W:0]   cnt_r;
    logic [1:0]        wait_cnt_r;
    logic [DATA_W-1:0] word_r;
    logic [7:0]        tx_data_r;
    logic              tx_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              eoe_q_r;
    logic              handshake_s;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        csum_r;
`endif

    assign handshake_s = tx_valid_r && tx_ready;
    assign tx_data     = tx_data_r;
    assign tx_valid    = tx_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;

    // Dump sequencing FSM with all handshake outputs held in registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            wait_cnt_r <= 2'd0;
            word_r     <= '0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            eoe_q_r    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_r     <= 8'h00;
`endif
        end else begin
            eoe_q_r <= eoe;
            case (state_r)
                ST_IDLE: begin
                    if (eoe && !eoe_q_r && !done_r) begin
                        state_r <= ST_RD;
                        busy_r  <= 1'b1;
                        cnt_r   <= '0;
                    end
                end
                ST_RD: begin
                    wait_cnt_r <= 2'd0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // WAIT spans RD_LAT cycles so read data is settled on the last one
                    if (wait_cnt_r == WAIT_LAST) begin
                        word_r     <= ram_rdata;
                        tx_data_r  <= ram_rdata[DATA_W-1:DATA_W-8];
                        tx_valid_r <= 1'b1;
                        state_r    <= ST_HI;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 2'd1;
                    end
                end
                ST_HI: begin
                    if (handshake_s) begin
                        tx_data_r <= word_r[7:0];
                        state_r   <= ST_LO;
`ifdef DUMP_CHECKSUM_EN
                        csum_r    <= csum_r ^ tx_data_r;
`endif
                    end
                end
                ST_LO: begin
                    if (handshake_s) begin
`ifdef DUMP_CHECKSUM_EN
                        csum_r <= csum_r ^ tx_data_r;
`endif
                        if (cnt_r == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                            tx_data_r <= csum_r ^ tx_data_r;
                            state_r   <= ST_CSUM;
`else
                            tx_valid_r <= 1'b0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            state_r    <= ST_DONE;
`endif
                        end else begin
                            cnt_r      <= cnt_r + (ADDR_W + 1)'(1);
                            tx_valid_r <= 1'b0;
                            state_r    <= ST_RD;
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (handshake_s) begin
                        tx_valid_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        state_r    <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    tx_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // RAM port mux: the CPU owns the port except while a dump is running
    always_comb begin
        ram_addr = cpu_addr;
        ram_we   = cpu_we;
        ram_re   = cpu_re;
        if (busy_r) begin
            ram_addr = cnt_r[ADDR_W-1:0];
            ram_we   = 1'b0;
            ram_re   = (state_r == ST_RD);
        end else begin
            ram_addr = cpu_addr;
            ram_we   = cpu_we;
            ram_re   = cpu_re;
        end
    end

endmodule

// File: tb/tb_ram_dump_sequencer.sv
// Scoreboard bench: two sequencers (RD_LAT 1 and 3) share stimulus; each has its own RAM
// model and monitor that pops expected bytes computed from a reference copy of RAM.
module tb_ram_dump_sequencer;
    localparam int AW = 6;
    localparam int WC = 64;
`ifdef DUMP_CHECKSUM_EN
    localparam int NB = 2 * WC + 1;
`else
    localparam int NB = 2 * WC;
`endif

    logic        clk = 1'b0;
    logic        reset, eoe, cpu_we, cpu_re, tx_ready;
    logic [5:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic [5:0]  ram_addr  [2];
    logic        ram_we    [2];
    logic        ram_re    [2];
    logic [15:0] ram_rdata [2];
    logic [7:0]  tx_data   [2];
    logic        tx_valid  [2];
    logic        busy      [2];
    logic        done      [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int nhs [2];
    bit seen_first [2];
    bit rand_ready = 1'b0;
    bit hammer = 1'b0;
    logic [15:0] ref_mem [WC];
    logic [7:0]  exp_q0 [$];
    logic [7:0]  exp_q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input int g, input logic [7:0] act);
        int sz;
        logic [7:0] e;
        if (g == 0) sz = exp_q0.size();
        else sz = exp_q1.size();
        if (sz == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte inst%0d: got %0h, required no byte", g, act);
        end else begin
            if (g == 0) e = exp_q0.pop_front();
            else e = exp_q1.pop_front();
            check($sformatf("byte_inst%0d_idx%0d", g, nhs[g]), {24'd0, act}, {24'd0, e});
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        localparam int RDL = (g == 0) ? 1 : 3;
        logic [15:0] mem  [WC];
        logic [15:0] pipe [3];
        logic        pv, pr;
        logic [7:0]  pd;

        ram_dump_sequencer #(.ADDR_W(AW), .DATA_W(16), .WORD_COUNT(WC), .RD_LAT(RDL)) dut (
            .clk(clk), .reset(reset), .eoe(eoe),
            .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re),
            .ram_addr(ram_addr[g]), .ram_we(ram_we[g]), .ram_re(ram_re[g]),
            .ram_rdata(ram_rdata[g]), .tx_data(tx_data[g]), .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready), .busy(busy[g]), .done(done[g])
        );

        // Single-port RAM with RD_LAT-deep read pipeline
        always @(posedge clk) begin
            if (ram_we[g]) mem[ram_addr[g]] <= cpu_wdata;
            if (ram_re[g]) pipe[0] <= mem[ram_addr[g]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign ram_rdata[g] = pipe[RDL-1];

        // Monitor: latency, hold-while-stalled, write blocking and byte scoreboard
        always @(negedge clk) begin
            if (reset) begin
                pv = 1'b0;
            end else begin
                if (tx_valid[g] && !seen_first[g]) begin
                    seen_first[g] = 1'b1;
                    check($sformatf("first_valid_latency_rdlat%0d", RDL), cyc - start_cyc, 1 + RDL);
                end
                if (pv && !pr) begin
                    check($sformatf("hold_valid_inst%0d", g), {31'd0, tx_valid[g]}, 32'd1);
                    check($sformatf("hold_data_inst%0d", g), {24'd0, tx_data[g]}, {24'd0, pd});
                end
                if (busy[g] && cpu_we) check($sformatf("we_blocked_inst%0d", g), {31'd0, ram_we[g]}, 32'd0);
                if (tx_valid[g] && tx_ready) begin
                    pop_check(g, tx_data[g]);
                    nhs[g]++;
                end
                pv = tx_valid[g];
                pd = tx_data[g];
                pr = tx_ready;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
        if (hammer) begin
            cpu_we    = busy[0] && busy[1];
            cpu_addr  = 6'h03;
            cpu_wdata = 16'($urandom);
        end
    endtask

    // Expected stream comes straight from the reference RAM image
    task automatic start_dump();
        logic [7:0] cs;
        cs = 8'h00;
        exp_q0.delete();
        exp_q1.delete();
        for (int i = 0; i < WC; i++) begin
            exp_q0.push_back(ref_mem[i][15:8]);
            exp_q0.push_back(ref_mem[i][7:0]);
            cs = cs ^ ref_mem[i][15:8] ^ ref_mem[i][7:0];
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q0.push_back(cs);
`endif
        exp_q1 = exp_q0;
        nhs[0] = 0;
        nhs[1] = 0;
        seen_first[0] = 1'b0;
        seen_first[1] = 1'b0;
        start_cyc = cyc + 1;
        eoe = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000; i++) begin
            if (done[0] && done[1]) break;
            tick();
        end
        check("done_within_budget", {31'd0, done[0] && done[1]}, 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s_tx_valid_inst%0d", tag, g), {31'd0, tx_valid[g]}, 32'd0);
            check($sformatf("%s_busy_inst%0d", tag, g), {31'd0, busy[g]}, 32'd0);
            check($sformatf("%s_done_inst%0d", tag, g), {31'd0, done[g]}, {31'd0, exp_done});
        end
    endtask

    task automatic check_complete(input string tag);
        check_idle(tag, 1'b1);
        check({tag, "_queue0_empty"}, exp_q0.size(), 32'd0);
        check({tag, "_queue1_empty"}, exp_q1.size(), 32'd0);
        check({tag, "_byte_count0"}, nhs[0], NB);
        check({tag, "_byte_count1"}, nhs[1], NB);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; eoe = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; tx_ready = 1'b0;
        cpu_addr = 6'h00; cpu_wdata = 16'h0000;
        repeat (3) tick();
        check_idle("reset", 1'b0);
        for (int g = 0; g < 2; g++) check($sformatf("reset_tx_data_inst%0d", g), {24'd0, tx_data[g]}, 32'd0);
        reset = 1'b0;

        // Load RAM through the pass-through path
        for (int i = 0; i < WC; i++) begin
            cpu_we    = 1'b1;
            cpu_addr  = 6'(i);
            cpu_wdata = (i == 0) ? 16'hA55A : (i == 1) ? 16'h1234 : 16'($urandom);
            ref_mem[i] = cpu_wdata;
            if (i == 5) begin
                #1;
                for (int g = 0; g < 2; g++) begin
                    check($sformatf("pass_addr_inst%0d", g), {26'd0, ram_addr[g]}, 32'h05);
                    check($sformatf("pass_we_inst%0d", g), {31'd0, ram_we[g]}, 32'd1);
                end
                check_idle("pass", 1'b0);
            end
            tick();
        end
        cpu_we = 1'b0;

        // Dump with the first byte stalled, then random backpressure and CPU write attempts
        start_dump();
        repeat (12) tick();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("stall_valid_inst%0d", g), {31'd0, tx_valid[g]}, 32'd1);
            check($sformatf("stall_data_inst%0d", g), {24'd0, tx_data[g]}, 32'hA5);
        end
        rand_ready = 1'b1;
        hammer = 1'b1;
        wait_done();
        hammer = 1'b0;
        cpu_we = 1'b0;
        tick();
        check_complete("dump1");

        // A fresh eoe edge after completion must not restart
        eoe = 1'b0;
        repeat (3) tick();
        eoe = 1'b1;
        repeat (20) tick();
        check_idle("after_done", 1'b1);

        // Reset returns to IDLE; a new edge starts, then reset mid-dump
        reset = 1'b1;
        eoe = 1'b0;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check_idle("idle_no_edge", 1'b0);
        start_dump();
        hammer = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (nhs[0] >= 7) break;
            tick();
        end
        check("seven_bytes_seen", {31'd0, nhs[0] >= 7}, 32'd1);
        reset = 1'b1;
        tick();
        check_idle("mid_reset", 1'b0);

        // eoe still high: start is taken on the first cycle out of reset
        reset = 1'b0;
        start_dump();
        wait_done();
        hammer = 1'b0;
        cpu_we = 1'b0;
        tick();
        check_complete("dump2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
